// File: rtl/demux_4_reg_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
//   NUM_LANES    : number of output lanes
//   SEL_W        : width of the lane select
//   CNT_W        : width of the accepted-word counter
//   lane_state_t : per-lane occupancy state
package demux_4_reg_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 8;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux_4_reg_lane.sv
// demux_lane: one output lane of the demultiplexer. It holds a single word
// together with an EMPTY/FULL state.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   load  : capture d this cycle. Only asserted when the lane is EMPTY or is
//           being acked in the same cycle.
//   ack   : consumer takes the held word. Ignored while EMPTY.
//   d     : incoming word
//   q     : held word. It keeps its last value after the lane empties.
//   valid : lane holds an unconsumed word
module demux_lane
    import demux_4_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    lane_state_t state, state_nxt;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LANE_EMPTY;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            LANE_EMPTY: if (load) state_nxt = LANE_FULL;
            // A load while FULL always coincides with an ack, so the lane
            // refills in place and stays FULL.
            LANE_FULL:  if (!load && ack) state_nxt = LANE_EMPTY;
            default:    state_nxt = LANE_EMPTY;
        endcase
    end

    // output logic
    always_comb begin
        valid = (state == LANE_FULL);
    end

    // The holding register is not cleared on drain. Only reset zeroes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/demux_4_reg.sv
// demux_4_reg: registered 1-to-4 demultiplexer with valid/ready handshaking.
// A word on d is steered by select into one of four holding lanes. Each lane
// has its own valid/ack handshake.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   d            : input word
//   select       : destination lane 0..3
//   in_valid     : d/select valid this cycle
//   in_ready     : the block accepts d this cycle (combinational from
//                  select, q_ack and lane state)
//   q            : lane data, lane i at [i*WIDTH +: WIDTH]
//   q_valid      : lane i holds an unconsumed word
//   q_ack        : lane i consumer takes its word this cycle
//   accept_count : accepted words, modulo 256
module demux_4_reg
    import demux_4_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           d,
    input  logic [SEL_W-1:0]           select,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NUM_LANES*WIDTH-1:0] q,
    output logic [NUM_LANES-1:0]       q_valid,
    input  logic [NUM_LANES-1:0]       q_ack,
    output logic [CNT_W-1:0]           accept_count
);

    logic [NUM_LANES-1:0]            tgt;
    logic [NUM_LANES-1:0]            load;
    logic [NUM_LANES-1:0][WIDTH-1:0] q_lane;
    logic                            accept;

    // A target lane can take a word when it is empty, or when its current
    // word leaves in this same cycle. in_valid does not take part.
    assign in_ready = !q_valid[select] || q_ack[select];
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [SEL_W-1:0] ID = SEL_W'(i);

        // Decoder term: AND of each select bit or its inversion, chosen to
        // match this lane's index.
        assign tgt[i]  = in_valid && (&(select ~^ ID));
        assign load[i] = tgt[i] && in_ready;

        demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .ack   (q_ack[i]),
            .d     (d),
            .q     (q_lane[i]),
            .valid (q_valid[i])
        );
    end

    assign q = q_lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       accept_count <= '0;
        else if (accept) accept_count <= accept_count + 1'b1;
    end

endmodule

// File: tb/tb_demux_4_reg.sv
module tb_demux_4_reg;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  d;
    logic [1:0]    select;
    logic          in_valid;
    logic          in_ready;
    logic [4*W-1:0] q;
    logic [3:0]    q_valid;
    logic [3:0]    q_ack;
    logic [7:0]    accept_count;

    demux_4_reg #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .d            (d),
        .select       (select),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .q            (q),
        .q_valid      (q_valid),
        .q_ack        (q_ack),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    // Reference model. Each lane is a queue of words that were accepted but
    // not yet consumed, and the counter is a plain modulo-256 tally.
    logic [W-1:0] lq [4][$];
    logic [3:0]   exp_qv;
    logic         exp_rdy;
    logic [7:0]   exp_cnt;
    logic [7:0]   mdl_cnt;
    bit           chk_en;
    int           total, bad;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Drive one cycle of stimulus just after the rising edge. Take a
    // snapshot of the model state the DUT should show during this cycle.
    // If the model says the word is accepted, push it.
    task automatic step(input logic v, input logic [1:0] sel,
                        input logic [W-1:0] dd, input logic [3:0] ack);
        @(posedge clk); #1;
        in_valid = v; select = sel; d = dd; q_ack = ack;
        for (int i = 0; i < 4; i++) exp_qv[i] = (lq[i].size() != 0);
        exp_rdy = !exp_qv[sel] || ack[sel];
        exp_cnt = mdl_cnt;
        if (v && exp_rdy) begin
            lq[sel].push_back(dd);
            mdl_cnt = mdl_cnt + 8'd1;
        end
        chk_en = 1'b1;
    endtask

    // Monitor: mid-cycle, compare the handshake state with the snapshot.
    // Pop and compare each word that the consumer takes.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("in_ready", W'(in_ready), W'(exp_rdy));
            chk("q_valid", W'(q_valid), W'(exp_qv));
            chk("accept_count", W'(accept_count), W'(exp_cnt));
            for (int i = 0; i < 4; i++) begin
                if (exp_qv[i] && q_ack[i]) begin
                    if (lq[i].size() == 0) begin
                        total++; bad++;
                        $display("FAIL lane%0d_pop: got word %h want none", i, q[i*W +: W]);
                    end else begin
                        chk($sformatf("lane%0d_data", i), q[i*W +: W], lq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        chk_en = 1'b0; in_valid = 1'b0; q_ack = 4'h0;
        #2 reset = 1'b1;
        #1;
        chk("rst_q_valid", W'(q_valid), W'(4'h0));
        chk("rst_q_lo", q[2*W-1:0], '0);
        chk("rst_q_hi", q[4*W-1:2*W], '0);
        chk("rst_count", W'(accept_count), '0);
        chk("rst_in_ready", W'(in_ready), W'(1'b1));
        for (int i = 0; i < 4; i++) lq[i].delete();
        mdl_cnt = 8'd0;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; d = '0; select = '0; in_valid = 1'b0; q_ack = '0;
        mdl_cnt = 8'd0; chk_en = 1'b0; total = 0; bad = 0;
        exp_qv = '0; exp_rdy = 1'b1; exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_q_valid", W'(q_valid), W'(4'h0));
        chk("init_q_lo", q[2*W-1:0], '0);
        chk("init_q_hi", q[4*W-1:2*W], '0);
        chk("init_count", W'(accept_count), '0);
        chk("init_in_ready", W'(in_ready), W'(1'b1));
        @(negedge clk); reset = 1'b0;

        // Single word to lane 2. The other lanes stay untouched.
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'h0);
        step(1'b0, 2'd0, 32'h0, 4'h0);
        chk("dead_q2", q[2*W +: W], 32'hDEADBEEF);
        chk("dead_q0", q[0 +: W], '0);
        chk("dead_q3", q[3*W +: W], '0);
        step(1'b0, 2'd0, 32'h0, 4'h4);

        // Lane 1 back-pressure, then refill in place through a same-cycle ack.
        step(1'b1, 2'd1, 32'h1111_AAAA, 4'h0);
        step(1'b1, 2'd1, 32'h2222_BBBB, 4'h0);
        step(1'b1, 2'd1, 32'h2222_BBBB, 4'h2);
        step(1'b0, 2'd0, 32'h0, 4'h0);
        chk("refill_q1", q[W +: W], 32'h2222_BBBB);
        step(1'b0, 2'd0, 32'h0, 4'h2);

        // Lane 0 drains while lane 3 fills in the same edge.
        step(1'b1, 2'd0, 32'h0000_0C0C, 4'h0);
        step(1'b1, 2'd3, 32'h3333_0303, 4'h1);
        step(1'b0, 2'd0, 32'h0, 4'h8);
        chk("drained_q0_kept", q[0 +: W], 32'h0000_0C0C);

        // Randomized traffic.
        for (int n = 0; n < 400; n++)
            step(1'($urandom), 2'($urandom), $urandom, 4'($urandom));
        step(1'b0, 2'd0, 32'h0, 4'hF);

        // 256 back-to-back accepts across rotating lanes with continuous acks.
        do_reset();
        for (int n = 0; n < 256; n++)
            step(1'b1, 2'(n), $urandom, 4'hF);
        step(1'b0, 2'd0, 32'h0, 4'hF);
        #1 chk("wrap_count", W'(accept_count), '0);

        // Fill all four lanes, then reset asynchronously mid-cycle.
        for (int n = 0; n < 4; n++)
            step(1'b1, 2'(n), 32'hF00D_0000 + n, 4'h0);
        step(1'b0, 2'd0, 32'h0, 4'h0);
        #1 chk("full_q_valid", W'(q_valid), W'(4'hF));
        do_reset();

        step(1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b0, 2'd0, 32'h0, 4'hF);
        @(negedge clk); #1;
        chk("leftover", W'(lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
